// File: rtl/instr_issue_seq.sv
`default_nettype none
//============================================================================
// Module   : instr_issue_seq
// Function : Loads a decoded program, issues encoded instruction words to the
//            core, holds each for LAT cycles and captures the core result.
// Options  : SEQ_SKIP_INVALID_EN - entries with invalid opcodes are not issued
// Revision : 1.0
//============================================================================
module instr_issue_seq #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [5:0]        prog_opcode,
  input  logic [4:0]        prog_src1,
  input  logic [4:0]        prog_src2,
  input  logic [4:0]        prog_dest,
  input  logic              prog_clear,
  output logic              prog_full,
  output logic [ADDR_W:0]   prog_count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       instruction,
  input  logic [31:0]       core_result,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [31:0]       res_rd_data,
  output logic              res_invalid
);

  localparam int                 CNT_W       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0]   c_hold_load = CNT_W'(LAT - 1);
  localparam logic [ADDR_W:0]    c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]    c_one       = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_HOLD    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Program entries are stored pre-packed as {dest, src2, src1, opcode}.
  logic [20:0]       r_prog_mem [DEPTH];
  logic [31:0]       r_res_mem  [DEPTH];
  logic              r_inv_mem  [DEPTH];

  logic [ADDR_W:0]   r_prog_count;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [31:0]       r_instruction;
  logic [31:0]       r_rd_data;
  logic              r_rd_inv;

  logic [20:0]       w_entry;
  logic              w_entry_invalid;
  logic              w_last;
  logic              w_prog_wr;
  logic              w_skip;
  logic              w_capture;
  logic [31:0]       w_capture_data;
  logic              w_busy;
  logic              w_done;

  assign w_entry         = r_prog_mem[r_ptr];
  assign w_entry_invalid = (w_entry[5:0] < 6'd4) || (w_entry[5:0] > 6'd14);
  assign w_last          = ({1'b0, r_ptr} == (r_prog_count - c_one));
  assign prog_full       = (r_prog_count == c_depth);
  assign w_prog_wr       = (r_state == S_IDLE) && prog_we && !prog_full && !prog_clear;

`ifdef SEQ_SKIP_INVALID_EN
  // An invalid entry is retired in its ISSUE cycle without touching the core.
  assign w_skip = (r_state == S_ISSUE) && w_entry_invalid;
`else
  assign w_skip = 1'b0;
`endif

  assign w_capture      = (r_state == S_CAPTURE) || w_skip;
  assign w_capture_data = w_skip ? 32'd0 : core_result;

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A clear in the same cycle empties the program, so the run is empty.
        if (start) begin
          w_state_next = ((r_prog_count != '0) && !prog_clear) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        if (w_skip) begin
          w_state_next = w_last ? S_DONE : S_ISSUE;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (r_hold_cnt == '0) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_busy       = 1'b1;
        w_state_next = w_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_prog_count  <= '0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_instruction <= 32'd0;
      r_rd_data     <= 32'd0;
      r_rd_inv      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == S_IDLE) && prog_clear) begin
        r_prog_count <= '0;
      end else if (w_prog_wr) begin
        r_prog_count <= r_prog_count + c_one;
      end

      if ((r_state == S_ISSUE) && !w_skip) begin
        r_instruction <= {11'd0, w_entry};
        r_hold_cnt    <= c_hold_load;
      end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - CNT_W'(1);
      end

      if (r_state == S_DONE) begin
        r_ptr <= '0;
      end else if (w_capture && !w_last) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end

      r_rd_data <= r_res_mem[res_rd_addr];
      r_rd_inv  <= r_inv_mem[res_rd_addr];
    end
  end

  // Storage arrays carry no reset; their contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_prog_wr) begin
      r_prog_mem[r_prog_count[ADDR_W-1:0]] <= {prog_dest, prog_src2, prog_src1, prog_opcode};
    end
    if (w_capture) begin
      r_res_mem[r_ptr] <= w_capture_data;
      r_inv_mem[r_ptr] <= w_entry_invalid;
    end
  end

  assign prog_count  = r_prog_count;
  assign busy        = w_busy;
  assign done        = w_done;
  assign instruction = r_instruction;
  assign res_rd_data = r_rd_data;
  assign res_invalid = r_rd_inv;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_seq.sv
`default_nettype none
//============================================================================
// Module   : tb_instr_issue_seq
// Function : Randomized self-checking bench for instr_issue_seq against a
//            schedule-based reference model; honours SEQ_SKIP_INVALID_EN.
// Revision : 1.0
//============================================================================
module tb_instr_issue_seq;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int LAT    = 1;
  localparam int PER    = LAT + 2;
`ifdef SEQ_SKIP_INVALID_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [5:0]        prog_opcode;
  logic [4:0]        prog_src1;
  logic [4:0]        prog_src2;
  logic [4:0]        prog_dest;
  logic              prog_clear;
  logic              prog_full;
  logic [ADDR_W:0]   prog_count;
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       instruction;
  logic [31:0]       core_result;
  logic [ADDR_W-1:0] res_rd_addr;
  logic [31:0]       res_rd_data;
  logic              res_invalid;

  int checks   = 0;
  int failures = 0;
  bit hold_addr;

  always #5 clk = ~clk;

  instr_issue_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_opcode(prog_opcode), .prog_src1(prog_src1),
    .prog_src2(prog_src2), .prog_dest(prog_dest), .prog_clear(prog_clear),
    .prog_full(prog_full), .prog_count(prog_count),
    .start(start), .busy(busy), .done(done),
    .instruction(instruction), .core_result(core_result),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .res_invalid(res_invalid)
  );

  // ---------------- core model: result only valid once instruction is LAT cycles old
  function automatic logic [31:0] rf_val(input logic [4:0] r);
    case (r)
      5'd10:   return 32'd10000;
      5'd3:    return 32'd3070;
      default: return 32'(r) * 32'd1237 + 32'd5;
    endcase
  endfunction

  function automatic logic [31:0] core_f(input logic [31:0] w);
    logic [31:0] a, b;
    a = rf_val(w[10:6]);
    b = rf_val(w[15:11]);
    case (w[5:0])
      6'd4:    return a + b;
      6'd5:    return a - b;
      6'd6:    return a & b;
      6'd7:    return a | b;
      6'd8:    return a ^ b;
      6'd9:    return a << b[4:0];
      6'd10:   return a >> b[4:0];
      default: return a ^ ~b ^ {26'd0, w[5:0]};
    endcase
  endfunction

  int          age = 0;
  logic [31:0] last_instr = 32'd0;
  always @(negedge clk) begin
    if (instruction !== last_instr) begin
      last_instr = instruction;
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
  end
  assign core_result = (age >= LAT) ? core_f(instruction) : (32'hDEAD0000 | 32'(age));

  // ---------------- reference model: a run is a precomputed schedule of edges
  logic [20:0] m_prog [DEPTH];
  logic [31:0] m_res  [DEPTH];
  bit          m_inv  [DEPTH];
  bit          m_known[DEPTH];
  int          m_iss  [DEPTH];
  int          m_cap  [DEPTH];
  int          m_count, m_n, m_rel, m_end;
  bit          m_run, m_ready = 1'b0;
  logic [31:0] m_instr, m_rd;
  bit          m_rd_inv, m_rd_known;

  function automatic bit op_bad(input logic [5:0] op);
    return (op < 6'd4) || (op > 6'd14);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_count = 0; m_run = 1'b0; m_instr = 32'd0;
      m_rd = 32'd0; m_rd_inv = 1'b0; m_rd_known = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end else begin
      m_rd = m_res[res_rd_addr]; m_rd_inv = m_inv[res_rd_addr]; m_rd_known = m_known[res_rd_addr];
      if (m_run) begin
        m_rel++;
        for (int k = 0; k < m_n; k++) begin
          if (m_iss[k] == m_rel) m_instr = {11'd0, m_prog[k]};
          if (m_cap[k] == m_rel) begin
            m_res[k]   = (SKIP && op_bad(m_prog[k][5:0])) ? 32'd0 : core_f({11'd0, m_prog[k]});
            m_inv[k]   = op_bad(m_prog[k][5:0]);
            m_known[k] = 1'b1;
          end
        end
        if (m_rel == m_end + 1) m_run = 1'b0;
      end else begin
        if (start) begin
          int t;
          m_n = prog_clear ? 0 : m_count;
          t = 1;
          for (int k = 0; k < m_n; k++) begin
            if (SKIP && op_bad(m_prog[k][5:0])) begin
              m_iss[k] = -1; m_cap[k] = t; t += 1;
            end else begin
              m_iss[k] = t; m_cap[k] = t + LAT + 1; t += PER;
            end
          end
          m_end = t - 1; m_rel = 0; m_run = 1'b1;
        end
        if (prog_clear) begin
          m_count = 0;
        end else if (prog_we && m_count < DEPTH) begin
          m_prog[m_count] = {prog_dest, prog_src2, prog_src1, prog_opcode};
          m_count++;
        end
      end
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge, compare every output, then release pulses.
  task automatic step();
    @(negedge clk);
    if (m_ready) begin
      chk("busy",        32'(busy),       32'(m_run && (m_rel < m_end)));
      chk("done",        32'(done),       32'(m_run && (m_rel == m_end)));
      chk("instruction", instruction,     m_instr);
      chk("prog_count",  32'(prog_count), 32'(m_count));
      chk("prog_full",   32'(prog_full),  32'(m_count == DEPTH));
      if (m_rd_known) begin
        chk("res_rd_data", res_rd_data,      m_rd);
        chk("res_invalid", 32'(res_invalid), 32'(m_rd_inv));
      end
    end
    start = 1'b0; prog_we = 1'b0; prog_clear = 1'b0;
    if (!hold_addr) res_rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic load(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d);
    step();
    prog_we = 1'b1; prog_opcode = op; prog_src1 = s1; prog_src2 = s2; prog_dest = d;
  endtask

  function automatic logic [5:0] rand_op();
    if ($urandom_range(0, 3) != 0) return 6'($urandom_range(4, 14));
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic load_rand();
    load(rand_op(), 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic clear_prog();
    step();
    prog_clear = 1'b1;
  endtask

  // Start a run and wait for it to finish, injecting ignored pulses while busy.
  task automatic run_prog(input string tag, input bit strays);
    bit seen;
    bit ended;
    seen = 1'b0; ended = 1'b0;
    step();
    start = 1'b1;
    for (int n = 0; n < 400 && !ended; n++) begin
      step();
      if (done) seen = 1'b1;
      if (!m_run) ended = 1'b1;
      else if (strays && $urandom_range(0, 5) == 0) begin
        start = 1'b1; prog_we = 1'($urandom_range(0, 1)); prog_clear = ($urandom_range(0, 3) == 0);
        prog_opcode = rand_op();
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic read_at(input int a);
    step();
    hold_addr = 1'b1; res_rd_addr = ADDR_W'(a);
    step();
    hold_addr = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; prog_we = 1'b0; prog_clear = 1'b0; start = 1'b0; hold_addr = 1'b0;
    prog_opcode = '0; prog_src1 = '0; prog_src2 = '0; prog_dest = '0; res_rd_addr = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_count", 32'(prog_count), 32'd0);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_rd",    res_rd_data, 32'd0);

    // single add: encoding, result and end-of-run latency
    load(6'd4, 5'd10, 5'd3, 5'd31);
    step();
    start = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!done && cyc < 20);
    chk("t1_done_latency", 32'(cyc), 32'(LAT + 3));
    chk("t1_instr", instruction, 32'h001F1A84);
    read_at(0);
    chk("t1_result",  res_rd_data, 32'd13070);
    chk("t1_invalid", 32'(res_invalid), 32'd0);

    // 23-entry program with an out-of-range opcode at index 13
    clear_prog();
    for (int i = 0; i < 23; i++)
      load((i == 13) ? 6'd15 : 6'($urandom_range(4, 14)), 5'($urandom), 5'($urandom), 5'($urandom));
    run_prog("t2", 1'b0);
    for (int a = 0; a < 23; a++) read_at(a);
    read_at(13);
    chk("t2_inv13", 32'(res_invalid), 32'd1);
`ifdef SEQ_SKIP_INVALID_EN
    chk("t2_res13_zero", res_rd_data, 32'd0);
`endif
    read_at(12);
    chk("t2_inv12", 32'(res_invalid), 32'd0);

    // fill to capacity, then one extra write
    clear_prog();
    for (int i = 0; i < 31; i++) load_rand();
    step();
    chk("t3_not_full_31", 32'(prog_full), 32'd0);
    load_rand(); load_rand();
    step();
    chk("t3_full",  32'(prog_full), 32'd1);
    chk("t3_count", 32'(prog_count), 32'd32);
    run_prog("t3", 1'b1);

    // empty program
    clear_prog();
    step();
    start = 1'b1;
    step();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    step();
    chk("t4_done_drop", 32'(done), 32'd0);

    // ignored pulses mid-run, then reset mid-run
    for (int i = 0; i < 5; i++) load_rand();
    step();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b1; prog_we = 1'b1;
    end
    step();
    chk("t5_count_kept", 32'(prog_count), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_count", 32'(prog_count), 32'd0);
    chk("t5_instr", instruction, 32'd0);
    step();
    chk("t5_no_done", 32'(done), 32'd0);

    // randomized programs and reruns
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) clear_prog();
      if ($urandom_range(0, 4) == 0) begin
        step();
        prog_we = 1'b1; prog_clear = 1'b1;
      end
      for (int i = 0, n = $urandom_range(1, 12); i < n; i++) load_rand();
      run_prog("rand", 1'b1);
      for (int i = 0, n = $urandom_range(2, 8); i < n; i++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
